// File: rtl/dram_read_arbiter.sv
// Merges the DRAM read-address streams of N_PORT read pipelines into one command channel.
// In-order responses are routed back to the issuing pipeline through a port-tag FIFO.
module dram_read_arbiter #(
  parameter int N_PORT    = 2,
  parameter int GBW       = 32,
  parameter int DBW       = 32,
  parameter int CSIZE     = 4,
  parameter int TAG_DEPTH = 8,
  localparam int PBW      = (N_PORT > 1) ? $clog2(N_PORT) : 1,
  localparam int AW       = $clog2(TAG_DEPTH),
  localparam int CW       = $clog2(TAG_DEPTH + 1)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [N_PORT-1:0]                 i_ra_rdy,
  output logic [N_PORT-1:0]                 o_ra_ack,
  input  logic [N_PORT-1:0][GBW-1:0]        i_ra_addr,
  output logic                              o_ra_rdy,
  input  logic                              i_ra_ack,
  output logic [GBW-1:0]                    o_ra_addr,
  input  logic                              i_rd_rdy,
  output logic                              o_rd_ack,
  input  logic [CSIZE-1:0][DBW-1:0]         i_rd_data,
  output logic [N_PORT-1:0]                 o_rd_rdy,
  input  logic [N_PORT-1:0]                 i_rd_ack,
  output logic [CSIZE-1:0][DBW-1:0]         o_rd_data,
  output logic                              o_err
);

  logic                 r_raValid;
  logic [GBW-1:0]       r_raAddr;
  logic [PBW-1:0]       r_rrPtr;
  logic [PBW-1:0]       r_tagMem [TAG_DEPTH];
  logic [AW-1:0]        r_wrPtr;
  logic [AW-1:0]        r_rdPtr;
  logic [CW-1:0]        r_count;
  logic                 r_err;

  logic                 w_free;
  logic                 w_found;
  logic [PBW-1:0]       w_winner;
  logic [PBW-1:0]       w_idx;
  logic                 w_grant;
  logic                 w_empty;
  logic [PBW-1:0]       w_head;

  // Round-robin scan starting at r_rrPtr; first requesting port wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < N_PORT; k++) begin
      w_idx = PBW'((int'(r_rrPtr) + k) % N_PORT);
      if (!w_found && i_ra_rdy[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_free  = !r_raValid || i_ra_ack;
  assign w_grant = w_free && (r_count < CW'(TAG_DEPTH)) && w_found;
  assign w_empty = (r_count == '0);
  assign w_head  = r_tagMem[r_rdPtr];

  always_comb begin
    o_ra_ack = '0;
    if (w_grant) o_ra_ack[w_winner] = 1'b1;
  end

  always_comb begin
    o_rd_rdy = '0;
    if (i_rd_rdy && !w_empty) o_rd_rdy[w_head] = 1'b1;
  end

  assign o_rd_ack  = !w_empty && i_rd_ack[w_head];
  assign o_rd_data = i_rd_data;
  assign o_ra_rdy  = r_raValid;
  assign o_ra_addr = r_raAddr;
  assign o_err     = r_err;

  // Tag storage needs no reset: the pointers and count define what is live.
  always_ff @(posedge i_clk) begin
    if (w_grant) r_tagMem[r_wrPtr] <= w_winner;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_raValid <= 1'b0;
      r_raAddr  <= '0;
      r_rrPtr   <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_grant) begin
        r_raValid <= 1'b1;
        r_raAddr  <= i_ra_addr[w_winner];
        r_rrPtr   <= PBW'((int'(w_winner) + 1) % N_PORT);
        r_wrPtr   <= r_wrPtr + 1'b1;
      end else if (i_ra_ack) begin
        r_raValid <= 1'b0;
      end
      if (o_rd_ack) r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_grant, o_rd_ack})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A response with nothing outstanding cannot be routed; flag it until reset.
      if (i_rd_rdy && w_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: doc/dram_read_arbiter.md
Name: dram_read_arbiter

Overview:
- Merges the DRAM read-address streams (o_dramra) of N_PORT read pipelines into one DRAM read-command channel.
- Routes in-order DRAM read responses back to the originating pipeline's dramrd input.
- A port-tag FIFO records the grant order; the DRAM side returns data strictly in command order.
- Sits between the read pipelines and the DRAM controller.

Parameters:
- N_PORT, 2, number of read pipelines served (≥2)
- GBW, TauCfg::GLOBAL_ADDR_BW, DRAM address width
- DBW, TauCfg::DATA_BW, data word width
- CSIZE, TauCfg::CACHE_SIZE, words per DRAM response beat
- TAG_DEPTH, 8, maximum outstanding commands (power of 2)
- PBW (derived), $clog2(N_PORT), port tag width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_ra_rdy  in  [N_PORT]  per-port address valid (from pipeline dramra_rdy)
- o_ra_ack  out  [N_PORT]  per-port address accept
- i_ra_addr  in  GBW x [N_PORT]  per-port DRAM address
- o_ra_rdy  out  1  merged command valid to DRAM
- i_ra_ack  in  1  DRAM accepts command
- o_ra_addr  out  GBW  merged command address
- i_rd_rdy  in  1  DRAM response valid
- o_rd_ack  out  1  response consumed
- i_rd_data  in  DBW x [CSIZE]  response beat
- o_rd_rdy  out  [N_PORT]  per-port response valid
- i_rd_ack  in  [N_PORT]  per-port response accept
- o_rd_data  out  DBW x [CSIZE]  response beat, broadcast to all ports
- o_err  out  1  sticky protocol error

Behaviour:
- Handshake is rdy/ack. A transfer occurs in the cycle ack=1. ack is asserted only while rdy=1. rdy must hold, with stable payload, until ack.
- Command output stage: a single register (valid flag, address, tag).
  - "Free" means empty, or i_ra_ack=1 this cycle.
- Grant: granted in a cycle where all of the following hold: stage free, tag FIFO count < TAG_DEPTH, and some i_ra_rdy set.
  - Winner is the first set i_ra_rdy scanning from rr_ptr upward, mod N_PORT.
  - o_ra_ack[winner]=1 combinationally in the same cycle; all other acks are 0.
  - The register loads i_ra_addr[winner] on the next edge.
  - The winner index is pushed to the tag FIFO on the same edge.
  - rr_ptr becomes (winner+1) mod N_PORT.
- Latency from grant to o_ra_rdy: 1 cycle. Back-to-back grants are possible every cycle while DRAM acks every cycle.
- Full FIFO: when count == TAG_DEPTH, no grant, even if a pop occurs in the same cycle.
- Response path (combinational):
  - head = FIFO head tag.
  - o_rd_rdy[head] = i_rd_rdy && !empty; all other bits are 0.
  - o_rd_ack = i_rd_ack[head] && !empty.
  - o_rd_data = i_rd_data.
  - The FIFO pops on o_rd_ack.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Response with empty FIFO: i_rd_rdy=1 with count==0 gives o_rd_ack=0 and sets o_err=1. o_err is sticky until reset.
- Pointers are log2(TAG_DEPTH) bits and wrap naturally. count is $clog2(TAG_DEPTH+1) bits.
- Reset values:
  - o_ra_rdy=0, o_ra_addr=0, o_err=0, rr_ptr=0, FIFO count and pointers 0.
  - Combinational outputs follow: all o_ra_ack=0, all o_rd_rdy=0, o_rd_ack=0.
- Reset mid-operation drops the pending command and all outstanding tags. No output glitches beyond the reset cycle.

Test Plan:
- Single port: after reset, port0 presents 0x100, 0x140, 0x180 with DRAM always acking. Required: o_ra_addr sequence 0x100, 0x140, 0x180, each one cycle after its ack; 3 responses route to o_rd_rdy[0] only; FIFO count returns to 0.
- Round robin: N_PORT=2, both ports always rdy, addresses port0=0xA*, port1=0xB*. Required: grants alternate 0,1,0,1 starting with port0; responses return to ports 0,1,0,1 in that order.
- Backpressure/full: DRAM acks every command; responses withheld (i_rd_rdy=0). Required: exactly 8 grants, then all o_ra_ack=0. After one response is acked, exactly one more grant follows on the next cycle.
- Per-port response stall: head tag=1 with i_rd_ack[1]=0 for 5 cycles. Required: o_rd_rdy[1] held high, o_rd_ack=0; pop occurs only in the cycle i_rd_ack[1]=1.
- Spurious response: i_rd_rdy=1 with empty FIFO. Required: o_rd_ack=0, o_err=1 from the next cycle, held until i_rst.
- Mid-flight reset: 3 outstanding tags, i_rst pulsed 1 cycle. Required: o_ra_rdy=0 and count=0 afterward; next grant goes to port0 (rr_ptr=0).
